matmul_rd_sequencer: RTL and testbench
======================================

Name: matmul_rd_sequencer

Overview:
- Controller that sequences the A and B operand RAMs (64 x 8-bit, registered read port, read strobe on `we`) for one C = A x B matrix product.
- Both RAMs hold row-major N x N matrices.
- Issues read strobes and addresses to both RAMs, and generates the MAC control pulses aligned to the RAMs' 1-cycle read latency.
- Reports each completed output element and end of run. Sits between the top-level start/done handshake and the RAM A / RAM B / MAC datapath.

Parameters:
- N, 8, matrix dimension; legal values 2..16, N*N <= 2^ADDR_W.
- ADDR_W, 8, width of RAM address outputs.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- stall  in  1  freezes read issue while high (RUN state only)
- rd_en_a  out  1  read strobe to RAM A (drives its we)
- addr_a  out  ADDR_W  RAM A address, i*N+k
- rd_en_b  out  1  read strobe to RAM B (drives its we)
- addr_b  out  ADDR_W  RAM B address, k*N+j
- mac_en  out  1  RAM data valid this cycle; MAC must consume it
- mac_clr  out  1  with mac_en, MAC loads product instead of accumulating (k==0)
- out_valid  out  1  1-cycle pulse: MAC accumulator holds final C[i][j]
- out_addr  out  ADDR_W  C address i*N+j, valid with out_valid
- busy  out  1  high in any state other than IDLE
- done  out  1  1-cycle end-of-run pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, counters i/j/k=0. All outputs 0, including addresses. Takes effect without clock. Mid-run reset abandons the run; no done pulse.
- Counters: i, j, k, each $clog2(N) bits. Loop order i outer, j middle, k inner.
- Address arithmetic: unsigned, zero-extended to ADDR_W. No overflow, by the parameter rule.
- States:
  - IDLE: start=1 -> RUN with i=j=k=0. Otherwise stay.
  - RUN, each cycle with stall=0:
    - rd_en_a=rd_en_b=1; addresses registered from current (i,j,k).
    - k increments. k wraps N-1->0 with j++; j wraps with i++.
    - When the issued triple is (N-1,N-1,N-1) -> DRAIN.
  - RUN with stall=1: rd_en_a=rd_en_b=0, counters frozen. An already-issued read still completes.
  - DRAIN: 2 cycles, no reads, stall ignored. -> DONE.
  - DONE: done=1 for exactly 1 cycle -> IDLE.
- Timing, with start accepted at edge of cycle T:
  - Issue cycles are registered outputs, first at T+1.
  - mac_en is rd_en delayed by 1 cycle.
  - mac_clr = mac_en of a k==0 read.
  - out_valid = 1 cycle after the mac_en of each k==N-1 read. out_addr is registered alongside.
  - With no stall and N=8: reads T+1..T+512, mac_en T+2..T+513, out_valid T+10, T+18, ..., T+514, done T+515. busy is high T+1..T+515.
  - Each stall cycle in RUN delays all later events by 1.
- addr_a/addr_b hold their last value when rd_en is low. Downstream must qualify with rd_en/mac_en only.
- start while busy: ignored, no queueing. start held high: new run accepted in the IDLE cycle after DONE.
- Simultaneous stall and final issue: the final issue waits until stall drops. DRAIN is entered only after the last read is actually issued.
- Exactly N^3 reads, N^3 mac_en pulses, N^2 mac_clr pulses and N^2 out_valid pulses per run.

Test Plan:
- Assert rst_n=0 with clk stopped -> all outputs 0 immediately. Release, start=0 for 10 cycles -> busy=0, no strobes.
- N=8, start at T, stall=0 -> reads 1..9 issue (addr_a, addr_b) = (0,0),(1,8),...,(7,56),(0,1). First out_valid at T+10 with out_addr=0. 64 out_valid pulses total, last with out_addr=63 at T+514. done at T+515.
- N=8, stall=1 for 3 cycles starting at 5th issue -> identical address sequence. 512 mac_en, 64 mac_clr. done at T+518.
- start pulsed at T+100 during run -> no effect. start held high continuously -> second run's first read at T+517.
- rst_n=0 at 100th issue -> outputs 0 asynchronously, no done. Next start -> first read (0,0).
- N=2 -> 8 reads: (0,0),(1,2),(0,1),(1,3),(2,0),(3,2),(2,1),(3,3). out_addr 0,1,2,3. done at T+11.

Source files
------------

// File: rtl/matmul_rd_sequencer_if.sv
// Bundle between the matmul read sequencer and its surroundings:
// the start/done handshake, RAM A/B read ports and the MAC control.
interface matmul_rd_sequencer_if #(
  parameter int ADDR_W = 8
) ();
  logic              start;
  logic              stall;
  logic              rd_en_a;
  logic [ADDR_W-1:0] addr_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] addr_b;
  logic              mac_en;
  logic              mac_clr;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              busy;
  logic              done;

  modport master (
    output start, stall,
    input  rd_en_a, addr_a, rd_en_b, addr_b, mac_en, mac_clr,
    input  out_valid, out_addr, busy, done
  );

  modport slave (
    input  start, stall,
    output rd_en_a, addr_a, rd_en_b, addr_b, mac_en, mac_clr,
    output out_valid, out_addr, busy, done
  );
endinterface

// File: rtl/matmul_rd_sequencer.sv
// Walks (i,j,k) for C = A x B, strobing RAM A at i*N+k and RAM B at k*N+j,
// and emits MAC enable/clear and C-element pulses aligned to the 1-cycle RAM latency.
module matmul_rd_sequencer #(
  parameter int N      = 8,
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  matmul_rd_sequencer_if.slave  bus
);
  localparam int                CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]     LAST = CW'(N - 1);
  localparam logic [ADDR_W-1:0] NA   = ADDR_W'(N);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_i, r_j, r_k;
  logic              r_drain;
  logic [1:0]        r_vld_pipe;   // [0] read issued, [1] RAM data at MAC
  logic [ADDR_W-1:0] r_addr_a, r_addr_b;
  logic              r_k0_iss, r_kl_iss, r_kl_mac;
  logic [ADDR_W-1:0] r_c_iss, r_c_mac;
  logic              r_mac_clr, r_out_valid, r_busy, r_done;
  logic [ADDR_W-1:0] r_out_addr;

  logic              w_issue, w_last;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b, w_c;

  assign w_issue  = (r_state == RUN) && !bus.stall;
  assign w_last   = (r_i == LAST) && (r_j == LAST) && (r_k == LAST);
  assign w_addr_a = ADDR_W'(r_i) * NA + ADDR_W'(r_k);
  assign w_addr_b = ADDR_W'(r_k) * NA + ADDR_W'(r_j);
  assign w_c      = ADDR_W'(r_i) * NA + ADDR_W'(r_j);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_drain     <= 1'b0;
      r_vld_pipe  <= '0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_k0_iss    <= 1'b0;
      r_kl_iss    <= 1'b0;
      r_kl_mac    <= 1'b0;
      r_c_iss     <= '0;
      r_c_mac     <= '0;
      r_mac_clr   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // Tags ride along with the read so MAC/C-element pulses line up with RAM data.
      r_vld_pipe  <= {r_vld_pipe[0], w_issue};
      r_mac_clr   <= r_vld_pipe[0] & r_k0_iss;
      r_kl_mac    <= r_kl_iss;
      r_c_mac     <= r_c_iss;
      r_out_valid <= r_vld_pipe[1] & r_kl_mac;
      if (r_vld_pipe[1] && r_kl_mac) r_out_addr <= r_c_mac;
      r_busy      <= (r_state != IDLE);
      r_done      <= (r_state == DONE);

      if (w_issue) begin
        r_addr_a <= w_addr_a;
        r_addr_b <= w_addr_b;
        r_k0_iss <= (r_k == '0);
        r_kl_iss <= (r_k == LAST);
        r_c_iss  <= w_c;
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= RUN;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            if (w_last) begin
              r_state <= DRAIN;
              r_drain <= 1'b0;
            end
            if (r_k == LAST) begin
              r_k <= '0;
              if (r_j == LAST) begin
                r_j <= '0;
                r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
              end else begin
                r_j <= r_j + 1'b1;
              end
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (r_drain) r_state <= DONE;
          else         r_drain <= 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rd_en_a   = r_vld_pipe[0];
  assign bus.rd_en_b   = r_vld_pipe[0];
  assign bus.addr_a    = r_addr_a;
  assign bus.addr_b    = r_addr_b;
  assign bus.mac_en    = r_vld_pipe[1];
  assign bus.mac_clr   = r_mac_clr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_matmul_rd_sequencer.sv
// Bench for matmul_rd_sequencer: N=8 and N=2 instances, randomized stall,
// cycle-by-cycle comparison against a schedule derived from the loop order.
module tb_matmul_rd_sequencer;
  localparam int AW = 8;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  matmul_rd_sequencer_if #(.ADDR_W(AW)) bus8 ();
  matmul_rd_sequencer_if #(.ADDR_W(AW)) bus2 ();

  matmul_rd_sequencer #(.N(8), .ADDR_W(AW)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  matmul_rd_sequencer #(.N(2), .ADDR_W(AW)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic          sel;
  logic          o_rda, o_rdb, o_mac, o_clr, o_ov, o_busy, o_done;
  logic [AW-1:0] o_aa, o_ab, o_oa;

  always_comb begin
    if (sel) begin
      o_rda = bus2.rd_en_a; o_rdb = bus2.rd_en_b; o_aa = bus2.addr_a; o_ab = bus2.addr_b;
      o_mac = bus2.mac_en;  o_clr = bus2.mac_clr; o_ov = bus2.out_valid; o_oa = bus2.out_addr;
      o_busy = bus2.busy;   o_done = bus2.done;
    end else begin
      o_rda = bus8.rd_en_a; o_rdb = bus8.rd_en_b; o_aa = bus8.addr_a; o_ab = bus8.addr_b;
      o_mac = bus8.mac_en;  o_clr = bus8.mac_clr; o_ov = bus8.out_valid; o_oa = bus8.out_addr;
      o_busy = bus8.busy;   o_done = bus8.done;
    end
  end

  task automatic drive(input logic st, input logic sl);
    if (sel) begin bus2.start = st; bus2.stall = sl; end
    else     begin bus8.start = st; bus8.stall = sl; end
  endtask

  int rd_idx[4096];   // read number issued in cycle t after start, -1 if none
  bit st_sched[4096];

  // One run: the model lists the n-th read (n = i*N*N + j*N + k) in the n-th
  // unstalled cycle; MAC follows one cycle later, C element two cycles later.
  task automatic exercise_run(input int nn, input int pct, input int st_at, input int st_len,
                              input int pulse_at, input bit hold, input int abort_at);
    int n3, nn2, n, last, done_c, tend, p;
    int cnt_rd, cnt_mac, cnt_clr, cnt_ov;
    bit have, aborted;
    logic [AW-1:0] e_aa, e_ab, e_oa;
    logic e_rd, e_mac, e_clr, e_ov, e_busy, e_done;
    n3 = nn * nn * nn; nn2 = nn * nn;
    cnt_rd = 0; cnt_mac = 0; cnt_clr = 0; cnt_ov = 0;
    have = 0; aborted = 0; e_aa = '0; e_ab = '0; e_oa = '0;
    for (int t = 0; t < 4096; t++) begin
      rd_idx[t]   = -1;
      st_sched[t] = (pct > 0 && int'($urandom_range(99)) < pct) ||
                    (st_len > 0 && t >= st_at && t < st_at + st_len);
    end
    n = 0; last = 0;
    for (int t = 1; t < 4000 && n < n3; t++)
      if (!st_sched[t]) begin rd_idx[t] = n; n++; last = t; end
    done_c = last + 3;
    tend   = done_c + 1;

    @(negedge clk); drive(1'b1, 1'b0);
    @(posedge clk);
    for (int t = 1; t <= tend && !aborted; t++) begin
      @(negedge clk);
      drive(hold || (t == pulse_at), st_sched[t]);
      @(posedge clk); #1;
      e_rd = rd_idx[t] >= 0;
      if (e_rd) begin
        p = rd_idx[t];
        e_aa = AW'((p / nn2) * nn + p % nn);
        e_ab = AW'((p % nn) * nn + (p / nn) % nn);
      end
      e_mac  = rd_idx[t-1] >= 0;
      e_clr  = e_mac && (rd_idx[t-1] % nn == 0);
      e_ov   = (t >= 2) ? (rd_idx[t-2] >= 0 && rd_idx[t-2] % nn == nn - 1) : 1'b0;
      if (e_ov) e_oa = AW'(rd_idx[t-2] / nn);
      e_busy = t <= done_c;
      e_done = t == done_c;

      checks++;
      if ({o_rda, o_rdb} !== {e_rd, e_rd}) begin
        failures++; $display("FAIL rd_en N=%0d t=%0d got=%b%b exp=%b", nn, t, o_rda, o_rdb, e_rd);
      end
      if (e_rd || have) begin
        checks++;
        if (o_aa !== e_aa || o_ab !== e_ab) begin
          failures++;
          $display("FAIL addr N=%0d t=%0d got=(%0d,%0d) exp=(%0d,%0d)", nn, t, o_aa, o_ab, e_aa, e_ab);
        end
      end
      have = have || e_rd;
      checks++;
      if (o_mac !== e_mac || o_clr !== e_clr) begin
        failures++; $display("FAIL mac N=%0d t=%0d got en/clr=%b%b exp=%b%b", nn, t, o_mac, o_clr, e_mac, e_clr);
      end
      checks++;
      if (o_ov !== e_ov || (e_ov && o_oa !== e_oa)) begin
        failures++; $display("FAIL out N=%0d t=%0d got=%b@%0d exp=%b@%0d", nn, t, o_ov, o_oa, e_ov, e_oa);
      end
      checks++;
      if (o_busy !== e_busy || o_done !== e_done) begin
        failures++; $display("FAIL busy_done N=%0d t=%0d got=%b%b exp=%b%b", nn, t, o_busy, o_done, e_busy, e_done);
      end
      if (t <= done_c) begin
        cnt_rd += int'(o_rda); cnt_mac += int'(o_mac); cnt_clr += int'(o_clr); cnt_ov += int'(o_ov);
      end
      if (abort_at > 0 && rd_idx[t] == abort_at - 1) begin
        rst_n = 1'b0; #1;
        checks++;
        if ({o_rda, o_rdb, o_mac, o_clr, o_ov, o_busy, o_done, o_aa, o_ab, o_oa} !== '0) begin
          failures++; $display("FAIL midrun_reset_zero t=%0d rd=%b mac=%b busy=%b aa=%0d ab=%0d exp=all 0",
                               t, o_rda, o_mac, o_busy, o_aa, o_ab);
        end
        aborted = 1;
      end
    end
    if (!aborted) begin
      checks++;
      if (cnt_rd != n3 || cnt_mac != n3 || cnt_clr != nn2 || cnt_ov != nn2) begin
        failures++;
        $display("FAIL totals N=%0d got rd=%0d mac=%0d clr=%0d ov=%0d exp %0d/%0d/%0d/%0d",
                 nn, cnt_rd, cnt_mac, cnt_clr, cnt_ov, n3, n3, nn2, nn2);
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    #2 rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1); #1;
      checks++;
      if ({o_rda, o_rdb, o_mac, o_clr, o_ov, o_busy, o_done, o_aa, o_ab, o_oa} !== '0) begin
        failures++; $display("FAIL reset_no_clock sel=%0d rd=%b busy=%b aa=%0d got nonzero exp=all 0", s, o_rda, o_busy, o_aa);
      end
    end
    sel = 0;
    #2 rst_n = 1'b1;
    clk_en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_rda, o_mac, o_busy, o_done} !== 4'b0) begin
        failures++; $display("FAIL idle_quiet c=%0d got rd/mac/busy/done=%b%b%b%b exp=0000", c, o_rda, o_mac, o_busy, o_done);
      end
    end
  endtask

  task automatic test_run_nostall();    exercise_run(8, 0, 0, 0, 0, 0, 0); endtask
  task automatic test_stall_window();   exercise_run(8, 0, 5, 3, 0, 0, 0); endtask
  task automatic test_start_ignored();  exercise_run(8, 0, 0, 0, 100, 0, 0); endtask
  task automatic test_random_stall();   exercise_run(8, 30, 0, 0, 0, 0, 0); endtask

  task automatic test_start_held();
    exercise_run(8, 0, 0, 0, 0, 1, 0);
    @(posedge clk); #1;
    checks++;
    if (o_rda !== 1'b1 || o_aa !== '0 || o_ab !== '0) begin
      failures++; $display("FAIL held_start_second_run got rd=%b (%0d,%0d) exp rd=1 (0,0)", o_rda, o_aa, o_ab);
    end
    @(negedge clk); drive(1'b0, 1'b0); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_midrun_reset();
    exercise_run(8, 0, 0, 0, 0, 0, 100);
    @(negedge clk); rst_n = 1'b1; drive(1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({o_rda, o_busy, o_done} !== 3'b0) begin
        failures++; $display("FAIL after_abort c=%0d got rd/busy/done=%b%b%b exp=000", c, o_rda, o_busy, o_done);
      end
    end
  endtask

  task automatic test_n2();
    @(negedge clk); drive(1'b0, 1'b0);
    sel = 1;
    exercise_run(2, 0, 0, 0, 0, 0, 0);
    exercise_run(2, 40, 0, 0, 0, 0, 0);
    exercise_run(2, 0, 3, 2, 0, 0, 0);
  endtask

  initial begin
    bus8.start = 0; bus8.stall = 0; bus2.start = 0; bus2.stall = 0; sel = 0;
    test_reset();
    test_run_nostall();
    test_stall_window();
    test_start_ignored();
    test_start_held();
    test_midrun_reset();
    test_run_nostall();
    test_random_stall();
    test_n2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
